// File: rtl/i2c_bus_arbiter_pkg.sv
// Purpose : shared types, widths and round-robin helper for the I2C bus arbiter.
// Contents: arbiter FSM state type, requester id type, address/data widths,
//           rr_pick() winner selection.
package i2c_bus_arbiter_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_COMPLETE
  } state_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_t;

  // Winner among the active requesters; on contention the one not served last.
  // Only meaningful when at least one request is high.
  function automatic req_t rr_pick(input logic req_a, input logic req_b, input req_t last);
    if (req_a && req_b) begin
      return (last == REQ_A) ? REQ_B : REQ_A;
    end else if (req_a) begin
      return REQ_A;
    end else begin
      return REQ_B;
    end
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Purpose : bundles the requester-side and controller-side signals of the
//           I2C bus arbiter.
// Modports: slave  - the arbiter (takes requests and controller status,
//                    drives grants/results and controller commands)
//           master - the environment (requesters A/B plus I2C_Controller)
// Signals : ReqA/B, AddrA/B, RwA/B, WrDataA/B   requester transactions
//           GrantA/B, DoneA/B, RdData, Error    requester results
//           CtrlGo, CtrlAddr, CtrlRw, CtrlWrData controller command
//           CtrlBusy, CtrlDone, CtrlRdData      controller status
interface i2c_bus_arbiter_if
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = I2C_ADDR_W
);

  logic                  ReqA;
  logic                  ReqB;
  logic [ADDR_W-1:0]     AddrA;
  logic [ADDR_W-1:0]     AddrB;
  logic                  RwA;
  logic                  RwB;
  logic [I2C_DATA_W-1:0] WrDataA;
  logic [I2C_DATA_W-1:0] WrDataB;
  logic                  GrantA;
  logic                  GrantB;
  logic                  DoneA;
  logic                  DoneB;
  logic [I2C_DATA_W-1:0] RdData;
  logic                  Error;
  logic                  CtrlGo;
  logic [ADDR_W-1:0]     CtrlAddr;
  logic                  CtrlRw;
  logic [I2C_DATA_W-1:0] CtrlWrData;
  logic                  CtrlBusy;
  logic                  CtrlDone;
  logic [I2C_DATA_W-1:0] CtrlRdData;

  modport slave (
    input  ReqA, ReqB, AddrA, AddrB, RwA, RwB, WrDataA, WrDataB,
    input  CtrlBusy, CtrlDone, CtrlRdData,
    output GrantA, GrantB, DoneA, DoneB, RdData, Error,
    output CtrlGo, CtrlAddr, CtrlRw, CtrlWrData
  );

  modport master (
    output ReqA, ReqB, AddrA, AddrB, RwA, RwB, WrDataA, WrDataB,
    output CtrlBusy, CtrlDone, CtrlRdData,
    input  GrantA, GrantB, DoneA, DoneB, RdData, Error,
    input  CtrlGo, CtrlAddr, CtrlRw, CtrlWrData
  );

endinterface

// File: rtl/i2c_bus_arbiter_timeout_counter.sv
// Purpose : saturating cycle counter bounding how long the arbiter waits for
//           the I2C controller.
// Ports   : clock      in  system clock
//           Reset      in  asynchronous active-low reset
//           i_clear    in  restart count from zero (wins over enable)
//           i_enable   in  count one cycle
//           o_terminal out count has reached TIMEOUT_CYCLES-1 (holds there)
module i2c_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clock,
  input  logic Reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int unsigned      CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  assign o_terminal = (r_count == TERM);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Purpose : shares one I2C_Controller between requester A (config loader) and
//           requester B (sensor poller). Round-robin grant, latches the
//           winner's transaction, pulses CtrlGo once, waits for CtrlDone or a
//           timeout and returns RdData/Error with a one-cycle Done pulse.
// Ports   : clock  in  system clock, rising edge
//           Reset  in  asynchronous active-low reset
//           arb    slave modport of i2c_bus_arbiter_if (requests, grants,
//                  results and the controller command/status handshake)
// All interface outputs come straight from registers.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned ADDR_W         = I2C_ADDR_W
) (
  input  logic            clock,
  input  logic            Reset,
  i2c_bus_arbiter_if.slave arb
);

  state_t                r_state,     w_state_nxt;
  req_t                  r_winner,    w_winner_nxt;
  req_t                  r_last,      w_last_nxt;
  req_t                  w_pick;
  logic                  r_grant_a,   w_grant_a_nxt;
  logic                  r_grant_b,   w_grant_b_nxt;
  logic                  r_done_a,    w_done_a_nxt;
  logic                  r_done_b,    w_done_b_nxt;
  logic [I2C_DATA_W-1:0] r_rd_data,   w_rd_data_nxt;
  logic                  r_error,     w_error_nxt;
  logic                  r_ctrl_go,   w_ctrl_go_nxt;
  logic [ADDR_W-1:0]     r_ctrl_addr, w_ctrl_addr_nxt;
  logic                  r_ctrl_rw,   w_ctrl_rw_nxt;
  logic [I2C_DATA_W-1:0] r_ctrl_wr,   w_ctrl_wr_nxt;
  logic                  w_tmr_clear;
  logic                  w_tmr_enable;
  logic                  w_tmr_terminal;

  i2c_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock      (clock),
    .Reset      (Reset),
    .i_clear    (w_tmr_clear),
    .i_enable   (w_tmr_enable),
    .o_terminal (w_tmr_terminal)
  );

  assign arb.GrantA     = r_grant_a;
  assign arb.GrantB     = r_grant_b;
  assign arb.DoneA      = r_done_a;
  assign arb.DoneB      = r_done_b;
  assign arb.RdData     = r_rd_data;
  assign arb.Error      = r_error;
  assign arb.CtrlGo     = r_ctrl_go;
  assign arb.CtrlAddr   = r_ctrl_addr;
  assign arb.CtrlRw     = r_ctrl_rw;
  assign arb.CtrlWrData = r_ctrl_wr;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_winner    <= REQ_A;
      r_last      <= REQ_B;   // A wins the first contention after reset
      r_grant_a   <= 1'b0;
      r_grant_b   <= 1'b0;
      r_done_a    <= 1'b0;
      r_done_b    <= 1'b0;
      r_rd_data   <= '0;
      r_error     <= 1'b0;
      r_ctrl_go   <= 1'b0;
      r_ctrl_addr <= '0;
      r_ctrl_rw   <= 1'b0;
      r_ctrl_wr   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_winner    <= w_winner_nxt;
      r_last      <= w_last_nxt;
      r_grant_a   <= w_grant_a_nxt;
      r_grant_b   <= w_grant_b_nxt;
      r_done_a    <= w_done_a_nxt;
      r_done_b    <= w_done_b_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_error     <= w_error_nxt;
      r_ctrl_go   <= w_ctrl_go_nxt;
      r_ctrl_addr <= w_ctrl_addr_nxt;
      r_ctrl_rw   <= w_ctrl_rw_nxt;
      r_ctrl_wr   <= w_ctrl_wr_nxt;
    end
  end

  // Next-state and next-output logic. Done/RdData/Error are loaded on the
  // edge that enters COMPLETE so the Done pulse occupies the COMPLETE cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_winner_nxt    = r_winner;
    w_last_nxt      = r_last;
    w_grant_a_nxt   = r_grant_a;
    w_grant_b_nxt   = r_grant_b;
    w_done_a_nxt    = 1'b0;
    w_done_b_nxt    = 1'b0;
    w_rd_data_nxt   = r_rd_data;
    w_error_nxt     = r_error;
    w_ctrl_go_nxt   = 1'b0;
    w_ctrl_addr_nxt = r_ctrl_addr;
    w_ctrl_rw_nxt   = r_ctrl_rw;
    w_ctrl_wr_nxt   = r_ctrl_wr;
    w_tmr_clear     = 1'b0;
    w_tmr_enable    = 1'b0;
    w_pick          = rr_pick(arb.ReqA, arb.ReqB, r_last);

    case (r_state)
      ST_IDLE: begin
        if (arb.ReqA || arb.ReqB) begin
          w_winner_nxt = w_pick;
          w_state_nxt  = ST_LAUNCH;
          if (w_pick == REQ_A) begin
            w_grant_a_nxt   = 1'b1;
            w_ctrl_addr_nxt = arb.AddrA;
            w_ctrl_rw_nxt   = arb.RwA;
            w_ctrl_wr_nxt   = arb.WrDataA;
          end else begin
            w_grant_b_nxt   = 1'b1;
            w_ctrl_addr_nxt = arb.AddrB;
            w_ctrl_rw_nxt   = arb.RwB;
            w_ctrl_wr_nxt   = arb.WrDataB;
          end
        end
      end

      ST_LAUNCH: begin
        if (!arb.CtrlBusy) begin
          w_ctrl_go_nxt = 1'b1;
          w_tmr_clear   = 1'b1;
          w_state_nxt   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        w_tmr_enable = 1'b1;
        // CtrlDone is tested first so it wins a same-cycle timeout.
        if (arb.CtrlDone || w_tmr_terminal) begin
          w_state_nxt   = ST_COMPLETE;
          w_rd_data_nxt = arb.CtrlDone ? arb.CtrlRdData : '0;
          w_error_nxt   = !arb.CtrlDone;
          if (r_winner == REQ_A) begin
            w_done_a_nxt = 1'b1;
          end else begin
            w_done_b_nxt = 1'b1;
          end
        end
      end

      ST_COMPLETE: begin
        w_grant_a_nxt = 1'b0;
        w_grant_b_nxt = 1'b0;
        w_last_nxt    = r_winner;
        w_state_nxt   = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Purpose : self-checking bench for i2c_bus_arbiter (TIMEOUT_CYCLES=16).
// Expected transactions are queued when a request is driven and compared
// when the arbiter launches (CtrlGo) and completes (DoneA/DoneB).
module tb_i2c_bus_arbiter;

  typedef struct packed {
    logic       who_b;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wr;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  logic        clock;
  logic        Reset;
  int unsigned n_total = 0;
  int unsigned n_fail  = 0;
  exp_t        sb[$];
  logic        model_last_b = 1'b1;
  logic [29:0] all_outs;

  i2c_bus_arbiter_if #(.ADDR_W(7)) bus ();

  i2c_bus_arbiter #(
    .TIMEOUT_CYCLES(16),
    .ADDR_W        (7)
  ) dut (
    .clock (clock),
    .Reset (Reset),
    .arb   (bus)
  );

  assign all_outs = {bus.GrantA, bus.GrantB, bus.DoneA, bus.DoneB, bus.RdData, bus.Error,
                     bus.CtrlGo, bus.CtrlAddr, bus.CtrlRw, bus.CtrlWrData};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic who_b, input logic [6:0] addr, input logic rw,
                      input logic [7:0] wr, input logic [7:0] rd, input logic err);
    exp_t e;
    e.who_b = who_b; e.addr = addr; e.rw = rw; e.wr = wr; e.rd = rd; e.err = err;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic who_b, input logic [6:0] addr, input logic rw,
                           input logic [7:0] wr);
    if (who_b) begin
      bus.ReqB = 1'b1; bus.AddrB = addr; bus.RwB = rw; bus.WrDataB = wr;
    end else begin
      bus.ReqA = 1'b1; bus.AddrA = addr; bus.RwA = rw; bus.WrDataA = wr;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    Reset = 1'b0;
    model_last_b = 1'b1;
    @(negedge clock);
    Reset = 1'b1;
  endtask

  // Wait for a Done pulse, compare against the oldest expectation, drop the
  // winner's request and confirm the pulse/grant end one cycle later.
  task automatic wait_done(input int unsigned budget, output int unsigned n);
    logic seen;
    exp_t e;
    n = 0;
    while (!(bus.DoneA || bus.DoneB) && n < budget) begin
      @(negedge clock);
      n++;
    end
    seen = bus.DoneA | bus.DoneB;
    check("done_seen", {31'b0, seen}, 32'd1);
    if (seen && sb.size() != 0) begin
      e = sb.pop_front();
      check("done_who",   {30'b0, bus.DoneA, bus.DoneB},   e.who_b ? 32'd1 : 32'd2);
      check("done_grant", {30'b0, bus.GrantA, bus.GrantB}, e.who_b ? 32'd1 : 32'd2);
      check("done_rd",    {24'b0, bus.RdData}, {24'b0, e.rd});
      check("done_err",   {31'b0, bus.Error},  {31'b0, e.err});
      model_last_b = e.who_b;
      if (e.who_b) bus.ReqB = 1'b0;
      else         bus.ReqA = 1'b0;
      @(negedge clock);
      check("done_end", {28'b0, bus.GrantA, bus.GrantB, bus.DoneA, bus.DoneB}, 32'd0);
    end
  endtask

  // Act as the I2C controller for the oldest queued transaction. delay is the
  // number of cycles after the CtrlGo cycle+1 before CtrlDone; no CtrlDone is
  // given when a timeout is expected. exp_lat (if nonzero) is the required
  // CtrlGo-to-Done distance in cycles.
  task automatic serve(input int unsigned delay, input int unsigned exp_lat);
    int unsigned n_go;
    int unsigned n_wait;
    int unsigned n_lat;
    logic        seen;
    exp_t        e;
    n_go = 0;
    while (bus.CtrlGo !== 1'b1 && n_go < 40) begin
      @(negedge clock);
      n_go++;
    end
    seen = bus.CtrlGo;
    check("go_seen", {31'b0, seen}, 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", sb.size(), 32'd1);
      return;
    end
    e = sb[0];
    check("go_grant", {30'b0, bus.GrantA, bus.GrantB}, e.who_b ? 32'd1 : 32'd2);
    check("go_addr",  {25'b0, bus.CtrlAddr},   {25'b0, e.addr});
    check("go_rw",    {31'b0, bus.CtrlRw},     {31'b0, e.rw});
    check("go_wr",    {24'b0, bus.CtrlWrData}, {24'b0, e.wr});
    @(negedge clock);
    n_lat = 1;
    check("go_single", {31'b0, bus.CtrlGo}, 32'd0);
    if (!e.err) begin
      repeat (delay) @(negedge clock);
      n_lat += delay;
      bus.CtrlDone   = 1'b1;
      bus.CtrlRdData = e.rd;
      @(negedge clock);
      n_lat++;
      bus.CtrlDone   = 1'b0;
      bus.CtrlRdData = 8'hEE;
    end
    wait_done(40, n_wait);
    n_lat += n_wait;
    if (exp_lat != 0) check("go_to_done", n_lat, exp_lat);
  endtask

  // Both requesters raised together: the model decides who is served first.
  task automatic push_pair(input logic [6:0] addr_a, input logic [7:0] wr_a, input logic [7:0] rd_a,
                           input logic [6:0] addr_b, input logic [7:0] rd_b);
    drive_req(1'b0, addr_a, 1'b0, wr_a);
    drive_req(1'b1, addr_b, 1'b1, 8'h00);
    if (model_last_b) begin
      push(1'b0, addr_a, 1'b0, wr_a, rd_a, 1'b0);
      push(1'b1, addr_b, 1'b1, 8'h00, rd_b, 1'b0);
    end else begin
      push(1'b1, addr_b, 1'b1, 8'h00, rd_b, 1'b0);
      push(1'b0, addr_a, 1'b0, wr_a, rd_a, 1'b0);
    end
  endtask

  initial begin
    bus.ReqA = 1'b0; bus.ReqB = 1'b0;
    bus.AddrA = '0; bus.AddrB = '0;
    bus.RwA = 1'b0; bus.RwB = 1'b0;
    bus.WrDataA = '0; bus.WrDataB = '0;
    bus.CtrlBusy = 1'b0; bus.CtrlDone = 1'b0; bus.CtrlRdData = 8'hEE;

    // Reset state and single-request latency
    Reset = 1'b0;
    #1;
    check("reset_outs_in", {2'b0, all_outs}, 32'd0);
    #5 Reset = 1'b1;
    @(negedge clock);
    check("reset_outs", {2'b0, all_outs}, 32'd0);
    drive_req(1'b0, 7'h20, 1'b0, 8'h3C);
    push(1'b0, 7'h20, 1'b0, 8'h3C, 8'h00, 1'b0);
    @(negedge clock);
    check("t1_grant", {30'b0, bus.GrantA, bus.GrantB}, 32'd2);
    check("t1_nogo", {31'b0, bus.CtrlGo}, 32'd0);
    @(negedge clock);
    check("t1_go", {31'b0, bus.CtrlGo}, 32'd1);
    serve(2, 0);

    // Contention after reset: A first, then B, then alternation
    do_reset();
    push_pair(7'h11, 8'hAA, 8'h01, 7'h22, 8'hC3);
    serve(1, 0);
    serve(3, 0);
    push_pair(7'h33, 8'h55, 8'h10, 7'h44, 8'h7E);
    serve(0, 0);
    serve(2, 0);

    // CtrlDone while idle must not produce a Done
    bus.CtrlDone = 1'b1; bus.CtrlRdData = 8'hFF;
    @(negedge clock);
    bus.CtrlDone = 1'b0; bus.CtrlRdData = 8'hEE;
    @(negedge clock);
    check("idle_ctrldone", {28'b0, bus.GrantA, bus.GrantB, bus.DoneA, bus.DoneB}, 32'd0);

    // B read from 0x48; address changed after grant must not leak through
    drive_req(1'b1, 7'h48, 1'b1, 8'h00);
    push(1'b1, 7'h48, 1'b1, 8'h00, 8'hA5, 1'b0);
    @(negedge clock);
    bus.AddrB = 7'h12;
    serve(1, 0);

    // Timeout: no CtrlDone, Done 16 cycles after CtrlGo with Error=1, RdData=0
    drive_req(1'b0, 7'h50, 1'b0, 8'h01);
    push(1'b0, 7'h50, 1'b0, 8'h01, 8'h00, 1'b1);
    serve(0, 16);

    // CtrlDone on the timeout cycle wins
    drive_req(1'b1, 7'h51, 1'b0, 8'h02);
    push(1'b1, 7'h51, 1'b0, 8'h02, 8'h6B, 1'b0);
    serve(14, 16);

    // CtrlBusy held through 5 LAUNCH cycles delays a single CtrlGo
    bus.CtrlBusy = 1'b1;
    drive_req(1'b0, 7'h2A, 1'b0, 8'hF0);
    push(1'b0, 7'h2A, 1'b0, 8'hF0, 8'h00, 1'b0);
    @(negedge clock);
    check("t5_grant", {30'b0, bus.GrantA, bus.GrantB}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t5_busy_nogo", {31'b0, bus.CtrlGo}, 32'd0);
    end
    bus.CtrlBusy = 1'b0;
    @(negedge clock);
    check("t5_go", {31'b0, bus.CtrlGo}, 32'd1);
    serve(1, 0);

    // Reset during WAIT clears outputs at once; then B alone is granted
    drive_req(1'b0, 7'h3B, 1'b1, 8'h00);
    @(negedge clock);
    @(negedge clock);
    check("t6_go", {31'b0, bus.CtrlGo}, 32'd1);
    @(negedge clock);
    #2 Reset = 1'b0;
    #1;
    check("t6_reset_outs", {2'b0, all_outs}, 32'd0);
    model_last_b = 1'b1;
    bus.ReqA = 1'b0;
    @(negedge clock);
    check("t6_no_done", {30'b0, bus.DoneA, bus.DoneB}, 32'd0);
    Reset = 1'b1;
    drive_req(1'b1, 7'h48, 1'b1, 8'h00);
    push(1'b1, 7'h48, 1'b1, 8'h00, 8'h3D, 1'b0);
    @(negedge clock);
    check("t6_grantB", {30'b0, bus.GrantA, bus.GrantB}, 32'd1);
    serve(1, 0);

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
